// File: rtl/zero_flag_pipe.sv
// Pipelined zero-detect for the ALU result path with an NZCV flag register that
// commits all four flags together when a flag-setting operation retires.
module zero_flag_pipe #(
    parameter int WIDTH = 64,
    parameter int GROUP = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] result,
    input  logic             carry_in,
    input  logic             overflow_in,
    input  logic             set_flags,
    input  logic             flush,
    output logic             out_valid,
    output logic             zero,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flags_busy
);

    function automatic int calc_lat(input int w, input int g);
        int n;
        int s;
        n = w / g;
        s = 1;
        while (n > 1) begin
            n = (n + g - 1) / g;
            s = s + 1;
        end
        return s;
    endfunction

    localparam int LAT = calc_lat(WIDTH, GROUP);
    localparam int NS  = (LAT > 1) ? LAT - 1 : 1;

    // Bit j of the input lands in term j/GROUP; unused upper terms stay 0, so a
    // partial last group simply ORs fewer live bits.
    function automatic logic [WIDTH-1:0] group_or(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int j = 0; j < WIDTH; j++) begin
            r[j/GROUP] = r[j/GROUP] | x[j];
        end
        return r;
    endfunction

    logic [WIDTH-1:0] lvl    [NS];
    logic [WIDTH-1:0] term_q [NS];
    logic [3:0]       side_q [NS];   // {set_flags, N, C, V}
    logic [3:0]       side_d [NS];
    logic [NS-1:0]    valid_q;
    logic [NS-1:0]    valid_d;

    logic       ret_valid;
    logic [3:0] ret_side;
    logic       ret_zero;

    logic       out_valid_q;
    logic       zero_q;
    logic [3:0] nzcv_q;
    logic       busy_d;

    assign lvl[0] = result;

    genvar gi;
    generate
        for (gi = 1; gi < NS; gi++) begin : g_lvl
            assign lvl[gi] = term_q[gi-1];
        end
    endgenerate

    always_comb begin
        valid_d   = '0;
        valid_d[0] = in_valid;
        side_d[0]  = {set_flags, result[WIDTH-1], carry_in, overflow_in};
        for (int s = 1; s < NS; s++) begin
            valid_d[s] = valid_q[s-1] & ~flush;
            side_d[s]  = side_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < NS; s++) begin
            term_q[s] <= group_or(lvl[s]);
            side_q[s] <= side_d[s];
        end
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // With a single-stage pipe the output register samples the inputs directly,
    // so an operation presented alongside flush is still accepted.
    generate
        if (LAT == 1) begin : g_ret_direct
            assign ret_valid = in_valid;
            assign ret_side  = {set_flags, result[WIDTH-1], carry_in, overflow_in};
            assign ret_zero  = ~|result;
        end else begin : g_ret_pipe
            assign ret_valid = valid_q[LAT-2] & ~flush;
            assign ret_side  = side_q[LAT-2];
            assign ret_zero  = ~|term_q[LAT-2];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            nzcv_q      <= 4'b0000;
        end else begin
            out_valid_q <= ret_valid;
            if (ret_valid) begin
                zero_q <= ret_zero;
                if (ret_side[3]) begin
                    nzcv_q <= {ret_side[2], ret_zero, ret_side[1], ret_side[0]};
                end
            end
        end
    end

    always_comb begin
        busy_d = 1'b0;
        for (int s = 0; s < LAT - 1; s++) begin
            busy_d = busy_d | (valid_q[s] & side_q[s][3]);
        end
    end

    assign out_valid  = out_valid_q;
    assign zero       = zero_q;
    assign flag_n     = nzcv_q[3];
    assign flag_z     = nzcv_q[2];
    assign flag_c     = nzcv_q[1];
    assign flag_v     = nzcv_q[0];
    assign flags_busy = busy_d;

endmodule
